// File: rtl/carfield_addr_map_unit.sv
// Runtime-programmable address map: a rule table of base/size/enable feeding a 2-stage lookup pipeline.
// Optional overlap scanner and status register at 0x108 are built when CARFIELD_ADDR_MAP_OVERLAP_CHK_EN is defined.
module carfield_addr_map_unit #(
  parameter int NumRules   = 8,
  parameter int AddrWidth  = 64,
  parameter int DefaultIdx = 0,
  parameter int IdxWidth   = $clog2(NumRules + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [8:0]           cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lkup_valid_i,
  output logic                 lkup_ready_o,
  input  logic [AddrWidth-1:0] lkup_addr_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [IdxWidth-1:0]  res_idx_o,
  output logic                 res_hit_o,
  output logic                 res_multi_o
);

  logic [AddrWidth-1:0] base_reg [NumRules];
  logic [AddrWidth-1:0] size_reg [NumRules];
  logic [AddrWidth:0]   end_arr  [NumRules];
  logic [NumRules-1:0]  en_reg;
  logic                 lock_reg;

  logic [3:0]  rule_sel;
  logic [1:0]  word_sel;
  logic        rule_map, en_map, lock_map, addr_mapped, wr_ok;
  logic [31:0] rd_val;

  // Registers are up to 64 bits wide; narrower widths drop the bits above AddrWidth.
  function automatic logic [AddrWidth-1:0] merge_word(input logic [AddrWidth-1:0] old,
                                                      input logic hi, input logic [31:0] d);
    logic [63:0] t;
    t = 64'(old);
    if (hi) t[63:32] = d;
    else    t[31:0]  = d;
    return t[AddrWidth-1:0];
  endfunction

  function automatic logic [31:0] pick_word(input logic [AddrWidth-1:0] v, input logic hi);
    logic [63:0] t;
    t = 64'(v);
    return hi ? t[63:32] : t[31:0];
  endfunction

  assign rule_sel = cfg_addr_i[7:4];
  assign word_sel = cfg_addr_i[3:2];
  assign rule_map = !cfg_addr_i[8] && (cfg_addr_i[1:0] == 2'b00) && (int'(rule_sel) < NumRules);
  assign en_map   = (cfg_addr_i == 9'h100);
  assign lock_map = (cfg_addr_i == 9'h104);

`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHK_EN
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

  scan_state_e scan_state_reg;
  logic [3:0]  pi_reg, pj_reg, fi_reg, fj_reg;
  logic        found_reg;
  logic        stat_map, scan_start, pair_ov;
  logic [AddrWidth-1:0] bi, bj;
  logic [AddrWidth:0]   ei, ej;
  logic        eni, enj;
  logic [31:0] scan_status;

  assign stat_map    = (cfg_addr_i == 9'h108);
  assign addr_mapped = rule_map || en_map || lock_map || stat_map;
  assign scan_status = {16'b0, fj_reg, fi_reg, 6'b0, found_reg, scan_state_reg == SCAN};
`else
  assign addr_mapped = rule_map || en_map || lock_map;
`endif

  assign wr_ok = cfg_req_i && cfg_we_i && !lock_reg && addr_mapped;

  always_comb begin
    rd_val = '0;
    if (rule_map) begin
      for (int i = 0; i < NumRules; i++) begin
        if (rule_sel == 4'(i))
          rd_val = word_sel[1] ? pick_word(size_reg[i], word_sel[0])
                               : pick_word(base_reg[i], word_sel[0]);
      end
    end else if (en_map) begin
      rd_val = 32'(en_reg);
    end else if (lock_map) begin
      rd_val = {31'b0, lock_reg};
    end
`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHK_EN
    else if (stat_map) begin
      rd_val = scan_status;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRules; i++) begin
        base_reg[i] <= '0;
        size_reg[i] <= '0;
      end
      en_reg   <= '0;
      lock_reg <= 1'b0;
    end else if (wr_ok) begin
      for (int i = 0; i < NumRules; i++) begin
        if (rule_map && rule_sel == 4'(i)) begin
          if (word_sel[1]) size_reg[i] <= merge_word(size_reg[i], word_sel[0], cfg_wdata_i);
          else             base_reg[i] <= merge_word(base_reg[i], word_sel[0], cfg_wdata_i);
        end
      end
      if (en_map) en_reg <= cfg_wdata_i[NumRules-1:0];
      if (lock_map && cfg_wdata_i[0]) lock_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i && !cfg_we_i;
      if (cfg_req_i && !cfg_we_i) cfg_rdata_o <= rd_val;
      cfg_err_o    <= cfg_req_i && (!addr_mapped || (cfg_we_i && lock_reg));
    end
  end

  // End is one bit wider than the address so a region reaching 2^AddrWidth never wraps.
  logic [NumRules-1:0] match_vec;
  for (genvar gi = 0; gi < NumRules; gi++) begin : g_match
    assign end_arr[gi]   = {1'b0, base_reg[gi]} + {1'b0, size_reg[gi]};
    assign match_vec[gi] = en_reg[gi] && (size_reg[gi] != '0) &&
                           (lkup_addr_i >= base_reg[gi]) && ({1'b0, lkup_addr_i} < end_arr[gi]);
  end

  logic                s1_valid_reg;
  logic [NumRules-1:0] s1_match_reg;
  logic                s2_ready;
  logic [IdxWidth-1:0] enc_idx;
  logic                multi_next;

  assign s2_ready     = !res_valid_o || res_ready_i;
  assign lkup_ready_o = !s1_valid_reg || s2_ready;
  assign multi_next   = (s1_match_reg & (s1_match_reg - NumRules'(1))) != '0;

  always_comb begin
    enc_idx = IdxWidth'(DefaultIdx);
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (s1_match_reg[i]) enc_idx = IdxWidth'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_reg <= 1'b0;
      s1_match_reg <= '0;
      res_valid_o  <= 1'b0;
      res_idx_o    <= '0;
      res_hit_o    <= 1'b0;
      res_multi_o  <= 1'b0;
    end else begin
      if (lkup_ready_o) begin
        s1_valid_reg <= lkup_valid_i;
        if (lkup_valid_i) s1_match_reg <= match_vec;
      end
      if (s2_ready) begin
        res_valid_o <= s1_valid_reg;
        if (s1_valid_reg) begin
          res_idx_o   <= enc_idx;
          res_hit_o   <= |s1_match_reg;
          res_multi_o <= multi_next;
        end
      end
    end
  end

`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHK_EN
  assign scan_start = wr_ok && en_map;

  always_comb begin
    bi = '0; bj = '0; ei = '0; ej = '0; eni = 1'b0; enj = 1'b0;
    for (int i = 0; i < NumRules; i++) begin
      if (pi_reg == 4'(i)) begin
        bi = base_reg[i]; ei = end_arr[i]; eni = en_reg[i];
      end
      if (pj_reg == 4'(i)) begin
        bj = base_reg[i]; ej = end_arr[i]; enj = en_reg[i];
      end
    end
    pair_ov = eni && enj && ({1'b0, bi} < ej) && ({1'b0, bj} < ei);
  end

  // One (i<j) pair per cycle in row-major order; any enable write restarts from (0,1).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_state_reg <= IDLE;
      pi_reg         <= '0;
      pj_reg         <= '0;
      found_reg      <= 1'b0;
      fi_reg         <= '0;
      fj_reg         <= '0;
    end else if (scan_start) begin
      scan_state_reg <= (NumRules > 1) ? SCAN : DONE;
      pi_reg         <= 4'd0;
      pj_reg         <= 4'd1;
      found_reg      <= 1'b0;
      fi_reg         <= '0;
      fj_reg         <= '0;
    end else begin
      case (scan_state_reg)
        SCAN: begin
          if (pair_ov && !found_reg) begin
            found_reg <= 1'b1;
            fi_reg    <= pi_reg;
            fj_reg    <= pj_reg;
          end
          if (pj_reg == 4'(NumRules - 1)) begin
            if (pi_reg == 4'(NumRules - 2)) begin
              scan_state_reg <= DONE;
            end else begin
              pi_reg <= pi_reg + 4'd1;
              pj_reg <= pi_reg + 4'd2;
            end
          end else begin
            pj_reg <= pj_reg + 4'd1;
          end
        end
        DONE:    scan_state_reg <= IDLE;
        default: scan_state_reg <= IDLE;
      endcase
    end
  end
`endif

endmodule
